load_store_unit: RTL and testbench

Memory-stage initiator that turns one RISC-V load/store request from the pipeline into byte-lane-correct accesses on the word-organised data memory port. It shifts store data and generates byte strobes. It splits misaligned accesses that cross a word boundary into two sequential word accesses. For loads it merges and sign- or zero-extends the returned data, and hands the pipeline a single registered response.

---
 rtl/load_store_unit.sv | 187 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: turns one RISC-V load/store request into word-organised memory
// accesses. Shifts store data into the correct byte lanes and builds the byte strobes.
// Splits accesses that cross a word boundary into two accesses, then merges and extends
// load data into one registered response.
module load_store_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_en,
  output logic        mem_we,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {StIdle, StAcc0, StAcc1, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q, wdata_q;
  logic [31:0] lo_q, lo_d;

  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;
  logic        mem_en_q, mem_en_d;
  logic        mem_we_q, mem_we_d;
  logic [3:0]  mem_wstrb_q, mem_wstrb_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;

  logic        accept;
  logic        cur_we;
  logic [2:0]  cur_f3;
  logic [31:0] cur_addr, cur_wdata;
  logic        illegal;
  logic [3:0]  size_mask;
  logic [7:0]  m8;
  logic [63:0] d64;
  logic        split;
  logic [31:0] base;
  logic [31:0] hi_word, lo_word, shifted, load_result;

  assign req_ready = (state_q == StIdle);
  assign accept    = req_valid && req_ready;

  // In IDLE the outputs for ACC0 are computed from the live request, since the
  // request registers only capture it at the accept edge.
  assign cur_we    = (state_q == StIdle) ? req_we     : we_q;
  assign cur_f3    = (state_q == StIdle) ? req_funct3 : f3_q;
  assign cur_addr  = (state_q == StIdle) ? req_addr   : addr_q;
  assign cur_wdata = (state_q == StIdle) ? req_wdata  : wdata_q;

  assign illegal = (cur_f3 == 3'b011) || (cur_f3[2:1] == 2'b11) || (cur_we && cur_f3[2]);

  // Lane mask, lane-positioned data and word-crossing detection
  always_comb begin
    size_mask = 4'b1111;
    unique case (cur_f3[1:0])
      2'b00:   size_mask = 4'b0001;
      2'b01:   size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
  end

  assign m8    = {4'b0000, size_mask} << cur_addr[1:0];
  assign d64   = {32'h0, cur_wdata} << {cur_addr[1:0], 3'b000};
  assign split = |m8[7:4];
  assign base  = {cur_addr[31:2], 2'b00};

  // Merge the two read words and extend to 32 bits (only used when leaving WAIT)
  always_comb begin
    hi_word = split ? mem_rdata : 32'h0;
    lo_word = split ? lo_q : mem_rdata;
    shifted = 32'({hi_word, lo_word} >> {addr_q[1:0], 3'b000});
    unique case (f3_q)
      3'b000:  load_result = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_result = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_result = {24'h0, shifted[7:0]};
      3'b101:  load_result = {16'h0, shifted[15:0]};
      default: load_result = shifted;
    endcase
  end

  // Next state plus next values of the registered outputs, keyed on the state entered
  always_comb begin
    state_d     = state_q;
    lo_d        = lo_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_wstrb_d = 4'b0000;
    mem_addr_d  = 32'h0;
    mem_wdata_d = 32'h0;

    unique case (state_q)
      StIdle: if (req_valid) state_d = illegal ? StResp : StAcc0;
      StAcc0: state_d = split ? StAcc1 : (we_q ? StResp : StWait);
      StAcc1: begin
        if (!we_q) lo_d = mem_rdata;
        state_d = we_q ? StResp : StWait;
      end
      StWait:  state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (state_d == StAcc0) begin
      mem_en_d    = 1'b1;
      mem_we_d    = cur_we;
      mem_addr_d  = base;
      mem_wstrb_d = cur_we ? m8[3:0] : 4'b0000;
      mem_wdata_d = d64[31:0];
    end else if (state_d == StAcc1) begin
      mem_en_d    = 1'b1;
      mem_we_d    = cur_we;
      mem_addr_d  = base + 32'd4;
      mem_wstrb_d = cur_we ? m8[7:4] : 4'b0000;
      mem_wdata_d = d64[63:32];
    end

    if (state_d == StResp) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = (state_q == StIdle);
      rsp_rdata_d = (state_q == StWait) ? load_result : 32'h0;
    end
  end

  // State, request capture and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      we_q        <= 1'b0;
      f3_q        <= 3'b000;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      lo_q        <= 32'h0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_wstrb_q <= 4'b0000;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      lo_q        <= lo_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_wstrb_q <= mem_wstrb_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if (accept) begin
        we_q    <= req_we;
        f3_q    <= req_funct3;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_wstrb = mem_wstrb_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: byte-level reference model plus scoreboard queue,
// a word-organised memory model on the memory port, directed and random requests.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_en, mem_we;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  load_store_unit dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_funct3(req_funct3),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_wstrb (mem_wstrb),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rd;
    bit          err;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    bit          we;
    logic [3:0]  strb;
    logic [31:0] wd;
  } acc_t;

  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  exp_t        exp_q[$];
  acc_t        acc_q[$];
  logic [31:0] dmem [logic [31:0]];  // DUT-side memory, word-keyed
  logic [7:0]  rmem [logic [31:0]];  // reference memory, byte-keyed

  function automatic logic [7:0] init_byte(logic [31:0] a);
    logic [7:0] t;
    t = (a[7:0] * 8'd29) ^ a[15:8] ^ a[31:24] ^ a[23:16] ^ 8'h5C;
    return t;
  endfunction

  function automatic logic [31:0] rd_word(logic [31:0] a);
    if (dmem.exists(a)) return dmem[a];
    return {init_byte(a + 32'd3), init_byte(a + 32'd2), init_byte(a + 32'd1), init_byte(a)};
  endfunction

  function automatic logic [7:0] ref_byte(logic [31:0] a);
    if (rmem.exists(a)) return rmem[a];
    return init_byte(a);
  endfunction

  // Behavioural reference: bytes at addr..addr+size-1 (wrapping), extended per funct3
  function automatic void model(input bit we, input bit [2:0] f3, input bit [31:0] a,
                                input bit [31:0] wd, output logic [31:0] rd,
                                output bit err, output int lat);
    int          sz;
    bit          sp;
    logic [31:0] v;
    err = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (we && f3 >= 3'd4);
    rd  = 32'h0;
    lat = 1;
    if (err) return;
    sz = 1 << f3[1:0];
    sp = (int'(a[1:0]) + sz) > 4;
    if (we) begin
      for (int i = 0; i < sz; i++) rmem[a + 32'(i)] = wd[8*i +: 8];
      lat = sp ? 3 : 2;
    end else begin
      v = 32'h0;
      for (int i = 0; i < sz; i++) v[8*i +: 8] = ref_byte(a + 32'(i));
      if (f3 == 3'd0) v = {{24{v[7]}}, v[7:0]};
      if (f3 == 3'd1) v = {{16{v[15]}}, v[15:0]};
      rd  = v;
      lat = sp ? 4 : 3;
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    dmem[a] = d;
    for (int i = 0; i < 4; i++) rmem[a + 32'(i)] = d[8*i +: 8];
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: strobed writes, read data one cycle after a read, junk otherwise
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_rdata <= 32'h0;
    end else begin
      if (mem_en) acc_q.push_back('{addr: mem_addr, we: mem_we, strb: mem_wstrb, wd: mem_wdata});
      if (mem_en && mem_we) begin
        logic [31:0] w;
        w = rd_word(mem_addr);
        for (int i = 0; i < 4; i++) if (mem_wstrb[i]) w[8*i +: 8] = mem_wdata[8*i +: 8];
        dmem[mem_addr] = w;
      end
      if (mem_en && !mem_we) mem_rdata <= rd_word(mem_addr);
      else mem_rdata <= $urandom;
    end
  end

  // Monitor: pops the scoreboard on every response and checks port invariants
  always @(negedge clk) begin
    if (!rst) begin
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_rsp: got rsp_valid, expected none (cycle %0d)", cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("rsp_rdata", rsp_rdata, e.rd);
          check("rsp_err", {31'h0, rsp_err}, {31'h0, e.err});
          check("rsp_cycle", cyc, e.cyc);
        end
      end
      if (mem_en) check("mem_addr_align", {30'h0, mem_addr[1:0]}, 32'h0);
      if (mem_en && !mem_we) check("load_wstrb", {28'h0, mem_wstrb}, 32'h0);
    end
  end

  task automatic issue(input bit we, input bit [2:0] f3, input bit [31:0] a,
                       input bit [31:0] wd, input bit push);
    int   n;
    exp_t e;
    int   lat;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL ready_timeout: got req_ready=0, expected 1 within 50 cycles");
      return;
    end
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    if (push) begin
      model(we, f3, a, wd, e.rd, e.err, lat);
      e.cyc = cyc + 1 + lat - 1;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL rsp_timeout: got %0d responses missing, expected 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic check_acc(input string name, input int idx, input logic [31:0] a,
                           input bit we, input logic [3:0] strb, input logic [31:0] wd,
                           input bit chk_wd);
    if (acc_q.size() > idx) begin
      check({name, "_addr"}, acc_q[idx].addr, a);
      check({name, "_we"}, {31'h0, acc_q[idx].we}, {31'h0, we});
      check({name, "_strb"}, {28'h0, acc_q[idx].strb}, {28'h0, strb});
      if (chk_wd) check({name, "_wdata"}, acc_q[idx].wd, wd);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_funct3 = 3'b000;
    req_addr = 32'h0;
    req_wdata = 32'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_req_ready", {31'h0, req_ready}, 32'h1);
    check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("rst_rsp_err", {31'h0, rsp_err}, 32'h0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_mem_en", {31'h0, mem_en}, 32'h0);
    check("rst_mem_we", {31'h0, mem_we}, 32'h0);
    check("rst_mem_wstrb", {28'h0, mem_wstrb}, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);

    // Aligned SW
    acc_q.delete();
    issue(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b1);
    drain();
    check("sw_nacc", acc_q.size(), 32'd1);
    check_acc("sw", 0, 32'h10, 1'b1, 4'b1111, 32'hDEADBEEF, 1'b1);

    // SB into top lane, then LB / LBU of it
    acc_q.delete();
    issue(1'b1, 3'b000, 32'h13, 32'h000000A5, 1'b1);
    drain();
    check("sb_nacc", acc_q.size(), 32'd1);
    check_acc("sb", 0, 32'h10, 1'b1, 4'b1000, 32'hA5000000, 1'b1);
    issue(1'b0, 3'b000, 32'h13, 32'h0, 1'b1);
    issue(1'b0, 3'b100, 32'h13, 32'h0, 1'b1);
    drain();

    // Split SW then LW
    acc_q.delete();
    issue(1'b1, 3'b010, 32'h0E, 32'h11223344, 1'b1);
    drain();
    check("ssw_nacc", acc_q.size(), 32'd2);
    check_acc("ssw0", 0, 32'h0C, 1'b1, 4'b1100, 32'h33440000, 1'b1);
    check_acc("ssw1", 1, 32'h10, 1'b1, 4'b0011, 32'h00001122, 1'b1);
    issue(1'b0, 3'b010, 32'h0E, 32'h0, 1'b1);
    drain();

    // Split LH wrapping past the top of the address space
    preload(32'hFFFFFFFC, 32'h80123456);
    preload(32'h00000000, 32'h1234567F);
    acc_q.delete();
    issue(1'b0, 3'b001, 32'hFFFFFFFF, 32'h0, 1'b1);
    drain();
    check("wrap_nacc", acc_q.size(), 32'd2);
    check_acc("wrap0", 0, 32'hFFFFFFFC, 1'b0, 4'b0000, 32'h0, 1'b0);
    check_acc("wrap1", 1, 32'h00000000, 1'b0, 4'b0000, 32'h0, 1'b0);

    // Illegal funct3: no memory access
    acc_q.delete();
    issue(1'b0, 3'b011, 32'h20, 32'h0, 1'b1);
    issue(1'b1, 3'b100, 32'h21, 32'h55, 1'b1);
    drain();
    check("err_nacc", acc_q.size(), 32'd0);

    // Reset during WAIT of an aligned load: dropped, no response
    issue(1'b0, 3'b010, 32'h20, 32'h0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_ready", {31'h0, req_ready}, 32'h1);
    check("midrst_mem_en", {31'h0, mem_en}, 32'h0);
    check("midrst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("midrst_mem_addr", mem_addr, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    issue(1'b0, 3'b010, 32'h10, 32'h0, 1'b1);
    drain();

    // Random traffic against the reference model
    for (int k = 0; k < 300; k++) begin
      bit        we;
      bit [2:0]  f3;
      bit [31:0] a;
      bit [31:0] wd;
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = 32'h100 + 32'($urandom_range(0, 63));
      wd = $urandom;
      issue(we, f3, a, wd, 1'b1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
